// File: rtl/ibex_crypto_ex_unit_pkg.sv
// Shared types and GF(2^8) helpers for the scalar-crypto EX unit.
package ibex_crypto_ex_unit_pkg;

    typedef enum logic [4:0] {
        SHA256_SIG0    = 5'd0,
        SHA256_SIG1    = 5'd1,
        SHA256_SUM0    = 5'd2,
        SHA256_SUM1    = 5'd3,
        SHA512_SIG0L   = 5'd4,
        SHA512_SIG0H   = 5'd5,
        SHA512_SIG1L   = 5'd6,
        SHA512_SIG1H   = 5'd7,
        SHA512_SUM0R   = 5'd8,
        SHA512_SUM1R   = 5'd9,
        AES32ESI       = 5'd10,
        AES32ESMI      = 5'd11,
        AES32DSI       = 5'd12,
        AES32DSMI      = 5'd13,
        AES_SUBWORD    = 5'd14,
        AES_INVSUBWORD = 5'd15
    } crypto_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } crypto_fsm_e;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] AES_POLY = 8'h1B;

    function automatic logic is_aes_op(crypto_op_e op);
        return op inside {AES32ESI, AES32ESMI, AES32DSI, AES32DSMI,
                          AES_SUBWORD, AES_INVSUBWORD};
    endfunction

    function automatic logic is_inv_op(crypto_op_e op);
        return op inside {AES32DSI, AES32DSMI, AES_INVSUBWORD};
    endfunction

    function automatic logic is_word_op(crypto_op_e op);
        return op inside {AES_SUBWORD, AES_INVSUBWORD};
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/ibex_crypto_ex_unit_sbox.sv
// Single-byte AES S-box, forward or inverse, built from GF inversion plus affine map.
module ibex_crypto_ex_unit_sbox
    import ibex_crypto_ex_unit_pkg::*;
#(
    parameter bit EnableInv = 1'b1
) (
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine_fwd(logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
               {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // Select forward or inverse substitution; inverse reads as zero when not built.
    always_comb begin
        data_o = 8'h00;
        if (!inv_i) begin
            data_o = affine_fwd(gf_inv(data_i));
        end else if (EnableInv) begin
            data_o = gf_inv(affine_inv(data_i));
        end
    end

endmodule

// File: rtl/ibex_crypto_ex_unit.sv
// Scalar-crypto EX unit: single-cycle SHA-2 ops, FSM-sequenced AES ops on a shared S-box bank.
module ibex_crypto_ex_unit
    import ibex_crypto_ex_unit_pkg::*;
#(
    parameter int unsigned SboxLanes    = 1,
    parameter bit          EnableSha512 = 1'b1,
    parameter bit          EnableInvAes = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        sel_i,
    input  crypto_op_e  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [1:0]  bs_i,
    input  logic        ready_id_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        busy_o
);

    localparam int unsigned Steps = 4 / SboxLanes;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

    crypto_fsm_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     result_q, result_d;
    crypto_op_e      op_q, op_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [1:0]      bs_q, bs_d;

    logic [1:0]      lane_idx [SboxLanes];
    logic [7:0]      lane_in  [SboxLanes];
    logic [7:0]      lane_out [SboxLanes];
    logic            lane_inv;

    function automatic logic [31:0] ror(logic [31:0] v, int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

    // SHA-256 sigma/sum and the RV32 split-word SHA-512 forms.
    function automatic logic [31:0] sha_word(crypto_op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (op)
            SHA256_SIG0:  r = ror(a, 7) ^ ror(a, 18) ^ (a >> 3);
            SHA256_SIG1:  r = ror(a, 17) ^ ror(a, 19) ^ (a >> 10);
            SHA256_SUM0:  r = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            SHA256_SUM1:  r = ror(a, 6) ^ ror(a, 11) ^ ror(a, 25);
            SHA512_SIG0L: r = (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 25) ^ (b << 24);
            SHA512_SIG0H: r = (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 24);
            SHA512_SIG1L: r = (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 26) ^ (b << 13);
            SHA512_SIG1H: r = (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 13);
            SHA512_SUM0R: r = (a << 25) ^ (a << 30) ^ (a >> 28) ^ (b >> 7) ^ (b >> 2) ^ (b << 4);
            SHA512_SUM1R: r = (a << 23) ^ (a >> 14) ^ (a >> 18) ^ (b >> 9) ^ (b << 18) ^ (b << 14);
            default:      r = 32'h0;
        endcase
        if (!EnableSha512 && op inside {SHA512_SIG0L, SHA512_SIG0H, SHA512_SIG1L,
                                        SHA512_SIG1H, SHA512_SUM0R, SHA512_SUM1R}) begin
            r = 32'h0;
        end
        return r;
    endfunction

    // One aes32* step: optional (Inv)MixColumn column, rotate into byte bs, fold into rs1.
    function automatic logic [31:0] aes32_word(crypto_op_e op, logic [7:0] s, logic [1:0] bs,
                                               logic [31:0] rs1);
        logic [31:0] col;
        logic [63:0] dbl;
        case (op)
            AES32ESMI: col = {gf_mul(s, 8'h03), s, s, gf_mul(s, 8'h02)};
            AES32DSMI: col = {gf_mul(s, 8'h0b), gf_mul(s, 8'h0d),
                              gf_mul(s, 8'h09), gf_mul(s, 8'h0e)};
            default:   col = {24'h0, s};
        endcase
        dbl = {col, col} << {bs, 3'b000};
        return rs1 ^ dbl[63:32];
    endfunction

    // Byte routing into the S-box bank: aes32* uses lane 0 on byte bs, SubWord walks upward.
    always_comb begin
        lane_inv = is_inv_op(op_q);
        for (int l = 0; l < SboxLanes; l++) begin
            int idx;
            idx         = int'(cnt_q) * int'(SboxLanes) + l;
            lane_idx[l] = idx[1:0];
            if (l == 0 && !is_word_op(op_q)) begin
                lane_in[l] = op_b_q[{bs_q, 3'b000} +: 8];
            end else begin
                lane_in[l] = op_b_q[{lane_idx[l], 3'b000} +: 8];
            end
        end
    end

    for (genvar l = 0; l < SboxLanes; l++) begin : g_sbox
        ibex_crypto_ex_unit_sbox #(
            .EnableInv(EnableInvAes)
        ) u_sbox (
            .data_i(lane_in[l]),
            .inv_i (lane_inv),
            .data_o(lane_out[l])
        );
    end

    // AES sequencing: latch on start, fill result over CALC, hold in DONE until accepted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        op_d     = op_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        bs_d     = bs_q;
        unique case (state_q)
            IDLE: begin
                if (en_i && sel_i && is_aes_op(op_i)) begin
                    op_d     = op_i;
                    op_a_d   = operand_a_i;
                    op_b_d   = operand_b_i;
                    bs_d     = bs_i;
                    cnt_d    = '0;
                    result_d = 32'h0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (!sel_i) begin
                    cnt_d    = '0;
                    result_d = 32'h0;
                    state_d  = IDLE;
                end else begin
                    if (is_word_op(op_q)) begin
                        for (int l = 0; l < SboxLanes; l++) begin
                            result_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
                        end
                        if (cnt_q == LastCnt) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        result_d = aes32_word(op_q, lane_out[0], bs_q, op_a_q);
                        state_d  = DONE;
                    end
                    // Without the inverse path every decrypt op yields zero, rs1 included.
                    if (lane_inv && !EnableInvAes) result_d = 32'h0;
                end
            end
            DONE: begin
                if (!sel_i || ready_id_i) begin
                    result_d = 32'h0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= 32'h0;
            op_q     <= SHA256_SIG0;
            op_a_q   <= 32'h0;
            op_b_q   <= 32'h0;
            bs_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            op_q     <= op_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            bs_q     <= bs_d;
        end
    end

    // Result mux: SHA/illegal ops answer from IDLE, AES from DONE; result zero unless valid.
    always_comb begin
        valid_o  = 1'b0;
        result_o = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (sel_i && !is_aes_op(op_i)) begin
                    valid_o  = 1'b1;
                    result_o = sha_word(op_i, operand_a_i, operand_b_i);
                end
            end
            DONE: begin
                if (sel_i) begin
                    valid_o  = 1'b1;
                    result_o = result_q;
                end
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_crypto_ex_unit.sv
// Randomized self-checking bench: default unit plus a 4-lane, no-SHA512, no-inverse variant.
module tb_ibex_crypto_ex_unit;
    import ibex_crypto_ex_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        sel_i = 1'b0;
    logic        ready_id_i = 1'b0;
    crypto_op_e  op_i = SHA256_SIG0;
    logic [31:0] operand_a_i = 32'h0;
    logic [31:0] operand_b_i = 32'h0;
    logic [1:0]  bs_i = 2'b00;

    logic [31:0] res_a, res_b;
    logic        valid_a, valid_b, busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t [256];

    always #5 clk_i = ~clk_i;

    ibex_crypto_ex_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .sel_i(sel_i), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .bs_i(bs_i),
        .ready_id_i(ready_id_i), .result_o(res_a), .valid_o(valid_a), .busy_o(busy_a)
    );

    ibex_crypto_ex_unit #(
        .SboxLanes(4), .EnableSha512(1'b0), .EnableInvAes(1'b0)
    ) dut_alt (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .sel_i(sel_i), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .bs_i(bs_i),
        .ready_id_i(ready_id_i), .result_o(res_b), .valid_o(valid_b), .busy_o(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Carry-less product reduced by long division with 0x11B.
    function automatic logic [7:0] ref_gmul(logic [7:0] a, logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        return prod[7:0];
    endfunction

    function automatic void build_tables();
        logic [7:0] c;
        logic [7:0] inv;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
                       inv[(i + 7) % 8] ^ c[i];
            end
            sbox_t[x]  = s;
            isbox_t[s] = 8'(x);
        end
    endfunction

    function automatic logic [31:0] ror32(logic [31:0] v, int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(logic [63:0] v, int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // SHA-512 results taken as the relevant half of the full 64-bit function.
    function automatic logic [31:0] ref_sha(crypto_op_e op, logic [31:0] a, logic [31:0] b,
                                            bit en512);
        logic [63:0] lo_x, hi_x, t;
        lo_x = {b, a};
        hi_x = {a, b};
        case (op)
            SHA256_SIG0: return ror32(a, 7) ^ ror32(a, 18) ^ (a >> 3);
            SHA256_SIG1: return ror32(a, 17) ^ ror32(a, 19) ^ (a >> 10);
            SHA256_SUM0: return ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22);
            SHA256_SUM1: return ror32(a, 6) ^ ror32(a, 11) ^ ror32(a, 25);
            default: ;
        endcase
        if (!en512) return 32'h0;
        case (op)
            SHA512_SIG0L: begin t = ror64(lo_x, 1) ^ ror64(lo_x, 8) ^ (lo_x >> 7); return t[31:0]; end
            SHA512_SIG0H: begin t = ror64(hi_x, 1) ^ ror64(hi_x, 8) ^ (hi_x >> 7); return t[63:32]; end
            SHA512_SIG1L: begin t = ror64(lo_x, 19) ^ ror64(lo_x, 61) ^ (lo_x >> 6); return t[31:0]; end
            SHA512_SIG1H: begin t = ror64(hi_x, 19) ^ ror64(hi_x, 61) ^ (hi_x >> 6); return t[63:32]; end
            SHA512_SUM0R: begin t = ror64(lo_x, 28) ^ ror64(lo_x, 34) ^ ror64(lo_x, 39); return t[31:0]; end
            SHA512_SUM1R: begin t = ror64(lo_x, 14) ^ ror64(lo_x, 18) ^ ror64(lo_x, 41); return t[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_aes(crypto_op_e op, logic [31:0] a, logic [31:0] b,
                                            logic [1:0] bs, bit en_inv);
        bit          dec;
        logic [7:0]  s;
        logic [31:0] w;
        logic [63:0] dbl;
        dec = (op == AES32DSI) || (op == AES32DSMI) || (op == AES_INVSUBWORD);
        if (dec && !en_inv) return 32'h0;
        if (op == AES_SUBWORD || op == AES_INVSUBWORD) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = dec ? isbox_t[b[8*k +: 8]] : sbox_t[b[8*k +: 8]];
            return w;
        end
        s = dec ? isbox_t[b[int'(bs)*8 +: 8]] : sbox_t[b[int'(bs)*8 +: 8]];
        if (op == AES32ESMI) w = {ref_gmul(s, 8'd3), s, s, ref_gmul(s, 8'd2)};
        else if (op == AES32DSMI) w = {ref_gmul(s, 8'd11), ref_gmul(s, 8'd13),
                                       ref_gmul(s, 8'd9), ref_gmul(s, 8'd14)};
        else w = {24'h0, s};
        dbl = {w, w} << (int'(bs) * 8);
        return a ^ dbl[63:32];
    endfunction

    task automatic run_sha(input crypto_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        sel_i = 1'b1; en_i = 1'($urandom); op_i = op;
        operand_a_i = a; operand_b_i = b; ready_id_i = 1'b1;
        #1;
        check_eq("sha_valid", 32'(valid_a), 32'd1);
        check_eq("sha_result", res_a, ref_sha(op, a, b, 1'b1));
        check_eq("sha_busy", 32'(busy_a), 32'd0);
        check_eq("sha_alt_valid", 32'(valid_b), 32'd1);
        check_eq("sha_alt_result", res_b, ref_sha(op, a, b, 1'b0));
    endtask

    // Issue one AES op with ready high, scramble inputs afterwards, find the single valid pulse.
    task automatic run_aes(input crypto_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] bs);
        int first_a, first_b, nv_a, nv_b, leak, lat_a;
        logic [31:0] got_a, got_b;
        first_a = 99; first_b = 99; nv_a = 0; nv_b = 0; leak = 0;
        got_a = 32'h0; got_b = 32'h0;
        lat_a = (op == AES_SUBWORD || op == AES_INVSUBWORD) ? 5 : 2;
        @(negedge clk_i);
        sel_i = 1'b1; en_i = 1'b1; op_i = op;
        operand_a_i = a; operand_b_i = b; bs_i = bs; ready_id_i = 1'b1;
        #1;
        if (valid_a || valid_b || res_a != 0 || res_b != 0) leak++;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            en_i = 1'b0; operand_a_i = $urandom; operand_b_i = $urandom; bs_i = 2'($urandom);
            #1;
            if (c == 1) check_eq("aes_busy_calc", 32'(busy_a), 32'd1);
            if (valid_a) begin
                nv_a++;
                if (first_a == 99) begin first_a = c; got_a = res_a; end
            end else if (res_a != 0) leak++;
            if (valid_b) begin
                nv_b++;
                if (first_b == 99) begin first_b = c; got_b = res_b; end
            end else if (res_b != 0) leak++;
        end
        sel_i = 1'b0;
        check_eq("aes_latency", 32'(first_a), 32'(lat_a));
        check_eq("aes_result", got_a, ref_aes(op, a, b, bs, 1'b1));
        check_eq("aes_pulses", 32'(nv_a), 32'd1);
        check_eq("aes_alt_latency", 32'(first_b), 32'd2);
        check_eq("aes_alt_result", got_b, ref_aes(op, a, b, bs, 1'b0));
        check_eq("aes_alt_pulses", 32'(nv_b), 32'd1);
        check_eq("aes_result_leak", 32'(leak), 32'd0);
    endtask

    initial begin
        int rose;
        logic [31:0] held;
        build_tables();

        // Reset: outputs zero and no FSM entry even with a start request present.
        sel_i = 1'b1; en_i = 1'b1; op_i = AES_SUBWORD;
        @(negedge clk_i); @(negedge clk_i); #1;
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_valid", 32'(valid_a), 32'd0);
        check_eq("rst_result", res_a, 32'h0);
        check_eq("rst_alt_busy", 32'(busy_b), 32'd0);
        sel_i = 1'b0; en_i = 1'b0;
        @(negedge clk_i); rst_ni = 1'b1;

        // Directed vectors.
        run_sha(SHA256_SIG0, 32'h1, 32'h0);
        check_eq("sig0_const", res_a, 32'h02004000);
        run_aes(AES32ESI, 32'h0, 32'h0, 2'd1);
        run_aes(AES32ESMI, 32'h0, 32'h0, 2'd0);
        run_aes(AES32DSI, 32'h0, 32'h0, 2'd3);
        run_aes(AES_SUBWORD, 32'h0, 32'h0, 2'd0);
        run_aes(AES_INVSUBWORD, $urandom, $urandom, 2'd2);

        // Illegal op: valid with zero result, no FSM entry.
        @(negedge clk_i);
        sel_i = 1'b1; en_i = 1'b1; op_i = crypto_op_e'(5'd20); operand_a_i = $urandom;
        operand_b_i = $urandom;
        #1;
        check_eq("illegal_valid", 32'(valid_a), 32'd1);
        check_eq("illegal_result", res_a, 32'h0);
        @(negedge clk_i); en_i = 1'b0; #1;
        check_eq("illegal_busy", 32'(busy_a), 32'd0);

        // Hold in DONE for 3 cycles; en_i while busy and on the exit cycle is ignored.
        @(negedge clk_i);
        sel_i = 1'b1; en_i = 1'b1; op_i = AES32ESMI; operand_a_i = 32'h0; operand_b_i = 32'h0;
        bs_i = 2'd0; ready_id_i = 1'b0;
        @(negedge clk_i); en_i = 1'b0;
        @(negedge clk_i); #1;
        check_eq("hold_c2_valid", 32'(valid_a), 32'd1);
        check_eq("hold_c2_result", res_a, 32'hA56363C6);
        check_eq("hold_c2_alt", res_b, 32'hA56363C6);
        held = res_a;
        @(negedge clk_i);
        en_i = 1'b1; operand_a_i = $urandom; operand_b_i = $urandom; bs_i = 2'($urandom);
        #1;
        check_eq("hold_c3_valid", 32'(valid_a), 32'd1);
        check_eq("hold_c3_result", res_a, held);
        @(negedge clk_i); ready_id_i = 1'b1; operand_b_i = $urandom; #1;
        check_eq("hold_c4_valid", 32'(valid_a), 32'd1);
        check_eq("hold_c4_result", res_a, held);
        @(negedge clk_i); en_i = 1'b0; #1;
        check_eq("hold_exit_valid", 32'(valid_a), 32'd0);
        check_eq("hold_exit_busy", 32'(busy_a), 32'd0);
        check_eq("hold_exit_alt_busy", 32'(busy_b), 32'd0);
        sel_i = 1'b0;

        // Kill: drop sel_i mid-CALC; no valid may ever appear.
        @(negedge clk_i);
        sel_i = 1'b1; en_i = 1'b1; op_i = AES_SUBWORD; operand_b_i = 32'h0; ready_id_i = 1'b0;
        rose = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            en_i = 1'b0;
            if (c == 2) sel_i = 1'b0;
            #1;
            if (valid_a || valid_b || res_a != 0 || res_b != 0) rose++;
        end
        check_eq("kill_no_valid", 32'(rose), 32'd0);
        check_eq("kill_busy", 32'(busy_a), 32'd0);
        check_eq("kill_alt_busy", 32'(busy_b), 32'd0);

        // Async reset while in DONE.
        @(negedge clk_i);
        sel_i = 1'b1; en_i = 1'b1; op_i = AES32ESI; operand_a_i = $urandom;
        operand_b_i = $urandom; bs_i = 2'($urandom); ready_id_i = 1'b0;
        @(negedge clk_i); en_i = 1'b0;
        @(negedge clk_i); #1;
        check_eq("prerst_valid", 32'(valid_a), 32'd1);
        rst_ni = 1'b0; #1;
        check_eq("midrst_valid", 32'(valid_a), 32'd0);
        check_eq("midrst_result", res_a, 32'h0);
        check_eq("midrst_busy", 32'(busy_a), 32'd0);
        check_eq("midrst_alt_valid", 32'(valid_b), 32'd0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i); #1;
        check_eq("postrst_busy", 32'(busy_a), 32'd0);
        check_eq("postrst_valid", 32'(valid_a), 32'd0);
        sel_i = 1'b0;

        // Randomized mix of all legal ops.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r <= 9) run_sha(crypto_op_e'(5'(r)), $urandom, $urandom);
            else run_aes(crypto_op_e'(5'(r)), $urandom, $urandom, 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
